cella_cmd_sched: RTL and testbench
==================================

# cella_cmd_sched

Command scheduler in front of the CELLA array controller. Accepts read/write/search commands from the host over a valid/ready handshake and buffers them in a small FIFO. Issues each command to the array control inputs for a programmable number of cycles, captures the array result, and returns one response per command over a second valid/ready handshake. Sequences the array so only one operation is in flight at a time, with the idle op code (2'b11) between operations.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- RD_CYC, 1, cycles a read is held on the array (≥1)
- WR_CYC, 2, cycles a write is held on the array (≥1)
- SR_CYC, 2, cycles a search is held on the array (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO not full
- cmd_op  in  2  00 read, 01 write, 10 search, 11 nop
- cmd_bank  in  4  bank address (write)
- cmd_col  in  3  column address (search)
- cmd_data  in  16  read_bar / write word / search query, passed unmasked
- arr_op_code  out  2  to array controller op_code
- arr_addr_bank  out  4  to array controller addr_bank
- arr_addr_col  out  3  to array controller addr_col
- arr_data  out  16  to array controller data
- arr_rdata  in  16  array result (read MAC / search match vector)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_op  out  2  op of the completed command
- rsp_data  out  16  captured result; 0 for write and nop
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- FIFO: push on cmd_valid && cmd_ready; cmd_ready = !full, independent of pop. Pop only on FSM entry to ISSUE.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: FIFO non-empty → pop, load head into arr_* registers, load counter with hold length L (RD_CYC/WR_CYC/SR_CYC), go ISSUE. Head op = nop → pop, go directly to RESP with rsp_data = 0; arr_op_code stays 11.
- ISSUE: arr_op_code = command op, addresses and data held stable. Counter decrements each cycle. On the last cycle (counter = 1), register arr_rdata into rsp_data (read, search) or 0 (write), then go RESP. arr_op_code returns to 11 in the same edge.
- RESP: rsp_valid = 1, rsp_op/rsp_data stable until rsp_valid && rsp_ready. On handshake: FIFO non-empty → go directly to ISSUE (or RESP for nop) with pop; else IDLE.
- While in RESP, arr_op_code = 11; arr_addr_*/arr_data hold last values.
- Counter width: clog2(max(RD_CYC, WR_CYC, SR_CYC)) + 1.

## Timing
- Reset values: arr_op_code = 2'b11; arr_addr_bank, arr_addr_col, arr_data, rsp_op, rsp_data = 0; rsp_valid = 0; busy = 0; cmd_ready = 1; FIFO empty; state IDLE.
- Command accepted at edge of cycle 0, FSM idle: cycle 1 pop; cycles 2..1+L ISSUE; cycle 2+L rsp_valid = 1. Read with RD_CYC = 1 gives response in cycle 3.
- Back-to-back: rsp handshake in cycle n, FIFO non-empty → next ISSUE starts cycle n+1. arr_op_code is 11 for at least one cycle between operations.
- Full FIFO: cmd_ready = 0 even in the cycle a pop occurs; it rises the cycle after the pop.
- Push and pop in the same cycle when non-full: both take effect; count unchanged.
- Response backpressure: rsp_ready low holds RESP indefinitely. The FIFO keeps accepting until full.
- rst asserted mid-ISSUE or mid-RESP: immediate return to reset values. In-flight and queued commands are discarded with no response.

## Structure
- Shared package cella_pkg: op code constants OP_READ, OP_WRITE, OP_SEARCH, OP_IDLE (2'b11), state enum, command struct {op, bank, col, data} (25 bits).
- Sub-module cella_cmd_fifo: parameterised synchronous FIFO with async active-high reset, full/empty, single-cycle push/pop.
- The FSM, counter and response registers live in cella_cmd_sched.

## Test plan
- Reset, then read (bank 0, col 0, data 16'h00F0), RD_CYC = 1, arr_rdata = 16'h1234 → arr_op_code = 00 in cycle 2 only; rsp_valid in cycle 3 with rsp_op = 00 and rsp_data = 16'h1234.
- Write bank 4'hA, data 16'hABCD, WR_CYC = 2 → arr_op_code = 01 and arr_addr_bank = A for exactly 2 cycles; rsp_data = 0.
- Push 5 commands back-to-back with DEPTH = 4 and rsp_ready = 0 → cmd_ready low after the FIFO fills. Then raise rsp_ready → 5 responses in order, with arr_op_code = 11 between operations.
- Search col 3, query 16'h0005, SR_CYC = 2, arr_rdata changes from 16'h0000 to 16'h8001 on the 2nd ISSUE cycle → rsp_data = 16'h8001.
- Nop command → no array activity (arr_op_code stays 11); rsp_valid 2 cycles after acceptance with rsp_op = 11 and rsp_data = 0.
- Assert rst during ISSUE of a write with 2 commands queued → all outputs return to reset values immediately; no responses after rst deasserts; busy = 0.

Source files
------------

// File: rtl/cella_pkg.sv
// Shared definitions for the CELLA command scheduler.
// Holds the op codes, the FSM state enum, the 25-bit command payload
// and a small helper used to size the hold counter.
package cella_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned BANK_W = 4;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [OP_W-1:0] OP_READ   = 2'b00;
  localparam logic [OP_W-1:0] OP_WRITE  = 2'b01;
  localparam logic [OP_W-1:0] OP_SEARCH = 2'b10;
  localparam logic [OP_W-1:0] OP_IDLE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // Largest of three hold lengths; sizes the issue counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cella_cmd_fifo.sv
// Synchronous command FIFO, single-cycle push/pop, show-ahead head output.
// Ports:
//   clk, rst        clock and async active-high reset
//   push, wdata     write strobe and command (ignored when full)
//   pop             read strobe (ignored when empty)
//   rdata           command at the head of the queue
//   full, empty     occupancy flags, derived from the registered count
module cella_cmd_fifo
  import cella_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  cmd_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cella_cmd_sched.sv
// Command scheduler in front of the CELLA array controller.
// Queues host commands, drives each onto the array for a per-op hold
// length, captures the array result and returns one response per command.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cmd_valid/cmd_ready              host command handshake
//   cmd_op/bank/col/data             command payload
//   arr_op_code/addr_bank/addr_col/data   array controller inputs
//   arr_rdata                        array result
//   rsp_valid/rsp_ready              response handshake
//   rsp_op, rsp_data                 completed op and captured result
//   busy                             work in flight or queued
module cella_cmd_sched
  import cella_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_CYC = 1,
  parameter int unsigned WR_CYC = 2,
  parameter int unsigned SR_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [OP_W-1:0]   arr_op_code,
  output logic [BANK_W-1:0] arr_addr_bank,
  output logic [COL_W-1:0]  arr_addr_col,
  output logic [DATA_W-1:0] arr_data,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OP_W-1:0]   rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(max3(RD_CYC, WR_CYC, SR_CYC)) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  cmd_t             push_cmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // Hold length for a given op; nop never enters ISSUE.
  function automatic logic [CNT_W-1:0] hold_len(input logic [OP_W-1:0] op);
    case (op)
      OP_READ:   return CNT_W'(RD_CYC);
      OP_WRITE:  return CNT_W'(WR_CYC);
      OP_SEARCH: return CNT_W'(SR_CYC);
      default:   return '0;
    endcase
  endfunction

  assign push_cmd  = '{op: cmd_op, bank: cmd_bank, col: cmd_col, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  // Pop only when the FSM starts the next command: from IDLE, or straight
  // out of RESP on the response handshake.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

  cella_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Scheduler FSM with registered array and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      arr_op_code   <= OP_IDLE;
      arr_addr_bank <= '0;
      arr_addr_col  <= '0;
      arr_data      <= '0;
      rsp_valid     <= 1'b0;
      rsp_op        <= '0;
      rsp_data      <= '0;
    end else begin
      case (state)
        ST_ISSUE: begin
          if (cnt == CNT_W'(1)) begin
            rsp_op      <= arr_op_code;
            rsp_data    <= (arr_op_code == OP_WRITE) ? '0 : arr_rdata;
            rsp_valid   <= 1'b1;
            arr_op_code <= OP_IDLE;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Starting the next command overrides the IDLE/RESP defaults above.
      if (pop) begin
        if (head.op == OP_IDLE) begin
          // nop: no array activity, answer immediately
          rsp_op    <= OP_IDLE;
          rsp_data  <= '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end else begin
          arr_op_code   <= head.op;
          arr_addr_bank <= head.bank;
          arr_addr_col  <= head.col;
          arr_data      <= head.data;
          cnt           <= hold_len(head.op);
          state         <= ST_ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cella_cmd_sched.sv
// Self-checking bench for cella_cmd_sched: table of single-command vectors
// plus hand-written sequences for search capture, FIFO fill/backpressure
// and mid-operation reset.
module tb_cella_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_bank;
  logic [2:0]  cmd_col;
  logic [15:0] cmd_data;
  logic [1:0]  arr_op_code;
  logic [3:0]  arr_addr_bank;
  logic [2:0]  arr_addr_col;
  logic [15:0] arr_data;
  logic [15:0] arr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [15:0] rsp_data;
  logic        busy;

  // Fake array: either a driven constant or an echo of the issued data.
  logic        echo;
  logic [15:0] rdata_drv;
  assign arr_rdata = echo ? (arr_data ^ 16'h5A5A) : rdata_drv;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cella_cmd_sched #(
    .DEPTH  (4),
    .RD_CYC (1),
    .WR_CYC (2),
    .SR_CYC (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_bank      (cmd_bank),
    .cmd_col       (cmd_col),
    .cmd_data      (cmd_data),
    .arr_op_code   (arr_op_code),
    .arr_addr_bank (arr_addr_bank),
    .arr_addr_col  (arr_addr_col),
    .arr_data      (arr_data),
    .arr_rdata     (arr_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_data      (rsp_data),
    .busy          (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  bank;
    logic [2:0]  col;
    logic [15:0] data;
    logic [15:0] rdata;
    int          hold;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  bank;
    logic [2:0]  col;
    logic [15:0] data;
  } cmd_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arr_op"},   32'(arr_op_code),   32'h3);
    chk({tag, "_arr_bank"}, 32'(arr_addr_bank), 32'h0);
    chk({tag, "_arr_col"},  32'(arr_addr_col),  32'h0);
    chk({tag, "_arr_data"}, 32'(arr_data),      32'h0);
    chk({tag, "_rsp_op"},   32'(rsp_op),        32'h0);
    chk({tag, "_rsp_data"}, 32'(rsp_data),      32'h0);
    chk({tag, "_rsp_valid"},32'(rsp_valid),     32'h0);
    chk({tag, "_busy"},     32'(busy),          32'h0);
    chk({tag, "_cmd_ready"},32'(cmd_ready),     32'h1);
  endtask

  task automatic drive_cmd(input cmd_s c);
    cmd_valid = 1'b1;
    cmd_op    = c.op;
    cmd_bank  = c.bank;
    cmd_col   = c.col;
    cmd_data  = c.data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    cmd_s q[5];
    logic [15:0] exp_q[5];
    int   pushed;
    int   got;
    int   guard;
    logic acc;
    logic overlap;
    logic seen_rsp;
    logic seen_act;
    logic [1:0] prev_op;

    vecs[0] = '{2'b00, 4'h0, 3'h0, 16'h00F0, 16'h1234, 1, 16'h1234};
    vecs[1] = '{2'b01, 4'hA, 3'h0, 16'hABCD, 16'h5555, 2, 16'h0000};
    vecs[2] = '{2'b10, 4'h0, 3'h5, 16'h0003, 16'h00FF, 2, 16'h00FF};
    vecs[3] = '{2'b11, 4'h0, 3'h0, 16'h0000, 16'h7777, 0, 16'h0000};
    vecs[4] = '{2'b00, 4'h3, 3'h1, 16'hFFFF, 16'hBEEF, 1, 16'hBEEF};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_bank  = '0;
    cmd_col   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    echo      = 1'b0;
    rdata_drv = '0;

    step();
    step();
    chk_reset_vals("rst_held");
    rst = 1'b0;
    step();
    chk_reset_vals("rst_released");

    // Table: one command at a time, cycle-exact op profile and response.
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      rdata_drv = v.rdata;
      drive_cmd('{v.op, v.bank, v.col, v.data});
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'h1);
      step();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      for (int c = 1; c <= 2 + v.hold; c++) begin
        logic in_issue;
        in_issue = (c >= 2) && (c <= 1 + v.hold);
        chk($sformatf("v%0d_c%0d_arr_op", i, c), 32'(arr_op_code),
            in_issue ? 32'(v.op) : 32'h3);
        chk($sformatf("v%0d_c%0d_rsp_valid", i, c), 32'(rsp_valid),
            (c == 2 + v.hold) ? 32'h1 : 32'h0);
        chk($sformatf("v%0d_c%0d_busy", i, c), 32'(busy), 32'h1);
        if (in_issue) begin
          chk($sformatf("v%0d_c%0d_bank", i, c), 32'(arr_addr_bank), 32'(v.bank));
          chk($sformatf("v%0d_c%0d_col", i, c),  32'(arr_addr_col),  32'(v.col));
          chk($sformatf("v%0d_c%0d_data", i, c), 32'(arr_data),      32'(v.data));
        end
        if (c == 2 + v.hold) begin
          chk($sformatf("v%0d_rsp_op", i),   32'(rsp_op),   32'(v.op));
          chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(v.exp_data));
          rsp_ready = 1'b1;
        end
        step();
      end
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_done", i), 32'(rsp_valid),   32'h0);
      chk($sformatf("v%0d_idle_op", i),  32'(arr_op_code), 32'h3);
      chk($sformatf("v%0d_not_busy", i), 32'(busy),        32'h0);
    end

    // Search: result changes on the second issue cycle, last value captured.
    rdata_drv = 16'h0000;
    drive_cmd('{2'b10, 4'h0, 3'h3, 16'h0005});
    step();
    cmd_valid = 1'b0;
    step();
    chk("sr_issue1_op",  32'(arr_op_code),  32'h2);
    chk("sr_issue1_col", 32'(arr_addr_col), 32'h3);
    chk("sr_issue1_data",32'(arr_data),     32'h0005);
    step();
    rdata_drv = 16'h8001;
    chk("sr_issue2_op",  32'(arr_op_code),  32'h2);
    step();
    chk("sr_rsp_valid",  32'(rsp_valid), 32'h1);
    chk("sr_rsp_op",     32'(rsp_op),    32'h2);
    chk("sr_rsp_data",   32'(rsp_data),  32'h8001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("sr_done", 32'(rsp_valid), 32'h0);

    // Fill the FIFO under response backpressure, then drain in order.
    echo = 1'b1;
    q[0] = '{2'b00, 4'h1, 3'h0, 16'h0011};
    q[1] = '{2'b01, 4'h2, 3'h0, 16'h0022};
    q[2] = '{2'b10, 4'h0, 3'h6, 16'h0033};
    q[3] = '{2'b11, 4'h0, 3'h0, 16'h0044};
    q[4] = '{2'b00, 4'h5, 3'h2, 16'h0055};
    foreach (q[i])
      exp_q[i] = (q[i].op == 2'b00 || q[i].op == 2'b10) ? (q[i].data ^ 16'h5A5A) : 16'h0000;
    pushed = 0;
    guard  = 0;
    while (pushed < 5 && guard < 50) begin
      drive_cmd(q[pushed]);
      acc = cmd_ready;
      step();
      if (acc) pushed++;
      guard++;
    end
    cmd_valid = 1'b0;
    chk("fill_pushed",     32'(pushed),    32'd5);
    chk("fill_guard",      32'(guard),     32'd5);
    chk("fill_cmd_ready",  32'(cmd_ready), 32'h0);
    chk("fill_busy",       32'(busy),      32'h1);
    chk("fill_rsp_valid",  32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    got     = 0;
    overlap = 1'b0;
    prev_op = arr_op_code;
    for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
      if (cyc == 0) chk("full_during_pop", 32'(cmd_ready), 32'h0);
      if (cyc == 1) chk("ready_after_pop", 32'(cmd_ready), 32'h1);
      if (prev_op != 2'b11 && arr_op_code != 2'b11 && arr_op_code != prev_op)
        overlap = 1'b1;
      prev_op = arr_op_code;
      if (rsp_valid) begin
        chk($sformatf("drain%0d_op", got),    32'(rsp_op),      32'(q[got].op));
        chk($sformatf("drain%0d_data", got),  32'(rsp_data),    32'(exp_q[got]));
        chk($sformatf("drain%0d_arr11", got), 32'(arr_op_code), 32'h3);
        got++;
      end
      step();
    end
    rsp_ready = 1'b0;
    chk("drain_count",   32'(got),     32'd5);
    chk("drain_no_overlap", 32'(overlap), 32'h0);
    chk("drain_not_busy",   32'(busy),    32'h0);
    echo = 1'b0;

    // Reset mid-ISSUE of a write with two reads queued.
    rdata_drv = 16'h9999;
    drive_cmd('{2'b01, 4'h7, 3'h0, 16'h1357});
    step();
    drive_cmd('{2'b00, 4'h1, 3'h1, 16'h0001});
    step();
    chk("rst_issue1_op", 32'(arr_op_code), 32'h1);
    drive_cmd('{2'b00, 4'h2, 3'h2, 16'h0002});
    step();
    cmd_valid = 1'b0;
    chk("rst_issue2_op",   32'(arr_op_code),   32'h1);
    chk("rst_issue2_bank", 32'(arr_addr_bank), 32'h7);
    chk("rst_pre_busy",    32'(busy),          32'h1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen_rsp = 1'b0;
    seen_act = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      if (arr_op_code != 2'b11) seen_act = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    chk("post_rst_no_rsp", 32'(seen_rsp), 32'h0);
    chk("post_rst_no_op",  32'(seen_act), 32'h0);
    chk("post_rst_busy",   32'(busy),     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
